pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs. Period, per-channel duty and alignment mode are double-buffered and applied only at period boundaries, so outputs never glitch. It sits between the processor-facing register block and the board PWM pins, and replaces the fixed 10-bit single-counter scheme.

---
 rtl/pwm_multichannel.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_multichannel.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// pwm_multichannel
//
// Multi-channel PWM generator. A single shared period counter is compared
// against one duty value per channel. Period, duty and alignment mode are
// written into a staging copy. They move to the active copy only when a new
// period starts, so a running output never sees a half-updated configuration.
//
// Ports
//   clk          : rising-edge clock; every state change happens on this edge
//   resetn       : synchronous active-low reset
//   en           : run enable; low holds the counter at 0 and the outputs low
//   load         : one-cycle strobe that captures period/duty/mode
//   period       : terminal count P
//   duty         : packed compare values; channel i uses bits [i*WIDTH +: WIDTH]
//   mode         : 0 = edge-aligned, 1 = center-aligned
//   cntr         : registered counter value
//   pwm_out      : registered PWM outputs, one per channel
//   period_start : high in the first cycle of every enabled period
//   pending      : staged values are waiting for the next period boundary

module pwm_multichannel #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      mode,
    output logic [WIDTH-1:0]          cntr,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      pending
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Counter and direction state.
    logic [WIDTH-1:0]          cntr_q, cntr_d;
    dir_e                      dir_q, dir_d;
    // Tracks whether the previous cycle was enabled, so that a rising en
    // restarts the period at 0.
    logic                      run_q, run_d;

    // Registered outputs.
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      start_q, start_d;
    logic                      pending_q, pending_d;

    // Active configuration, which is used by the counter and the compare.
    logic [WIDTH-1:0]          act_period_q, act_period_d;
    logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d;
    logic                      act_mode_q, act_mode_d;

    // Staged configuration, which waits for the next period boundary.
    logic [WIDTH-1:0]          stg_period_q, stg_period_d;
    logic [CHANNELS*WIDTH-1:0] stg_duty_q, stg_duty_d;
    logic                      stg_mode_q, stg_mode_d;

    // High on the edge at which a new period begins.
    logic                      wrap;

    // Next-state logic. Every disabled cycle is treated as a period boundary,
    // and so is the first enabled cycle after a disabled one. This lets staged
    // values apply at once while the block is idle. Center mode counts up to P
    // and then back down to 1. Small P values (0 and 1) wrap straight from the
    // top of the up count.
    always_comb begin
        cntr_d       = cntr_q;
        dir_d        = dir_q;
        run_d        = en;
        wrap         = 1'b0;
        pwm_d        = '0;
        start_d      = 1'b0;
        pending_d    = pending_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        act_mode_d   = act_mode_q;
        stg_period_d = stg_period_q;
        stg_duty_d   = stg_duty_q;
        stg_mode_d   = stg_mode_q;

        if (!en || !run_q) begin
            cntr_d = '0;
            dir_d  = DIR_UP;
            wrap   = 1'b1;
        end else if (!act_mode_q) begin
            dir_d = DIR_UP;
            if (cntr_q >= act_period_q) begin
                cntr_d = '0;
                wrap   = 1'b1;
            end else begin
                cntr_d = cntr_q + ONE;
            end
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (cntr_q >= act_period_q) begin
                        if (act_period_q <= ONE) begin
                            cntr_d = '0;
                            wrap   = 1'b1;
                        end else begin
                            cntr_d = act_period_q - ONE;
                            dir_d  = DIR_DOWN;
                        end
                    end else begin
                        cntr_d = cntr_q + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (cntr_q <= ONE) begin
                        cntr_d = '0;
                        dir_d  = DIR_UP;
                        wrap   = 1'b1;
                    end else begin
                        cntr_d = cntr_q - ONE;
                    end
                end
                default: begin
                    cntr_d = '0;
                    dir_d  = DIR_UP;
                    wrap   = 1'b1;
                end
            endcase
        end

        // A load that lands on the boundary edge bypasses staging. Staging is
        // also refreshed in that case, so that a later boundary with no load
        // re-applies the same values.
        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                act_period_d = period;
                act_duty_d   = duty;
                act_mode_d   = mode;
                stg_period_d = period;
                stg_duty_d   = duty;
                stg_mode_d   = mode;
            end else begin
                act_period_d = stg_period_q;
                act_duty_d   = stg_duty_q;
                act_mode_d   = stg_mode_q;
            end
        end else if (load) begin
            stg_period_d = period;
            stg_duty_d   = duty;
            stg_mode_d   = mode;
            pending_d    = 1'b1;
        end

        // The compare uses the next counter value and the next active duty.
        // This keeps pwm_out aligned with cntr after the registers update.
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en && (cntr_d < act_duty_d[i*WIDTH +: WIDTH]);
        end
        start_d = en && wrap;
    end

    // State register. A reset clears both configuration copies to P=all-ones,
    // D=0 and edge mode. Any staged data is lost.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cntr_q       <= '0;
            dir_q        <= DIR_UP;
            run_q        <= 1'b0;
            pwm_q        <= '0;
            start_q      <= 1'b0;
            pending_q    <= 1'b0;
            act_period_q <= '1;
            act_duty_q   <= '0;
            act_mode_q   <= 1'b0;
            stg_period_q <= '1;
            stg_duty_q   <= '0;
            stg_mode_q   <= 1'b0;
        end else begin
            cntr_q       <= cntr_d;
            dir_q        <= dir_d;
            run_q        <= run_d;
            pwm_q        <= pwm_d;
            start_q      <= start_d;
            pending_q    <= pending_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            act_mode_q   <= act_mode_d;
            stg_period_q <= stg_period_d;
            stg_duty_q   <= stg_duty_d;
            stg_mode_q   <= stg_mode_d;
        end
    end

    assign cntr         = cntr_q;
    assign pwm_out      = pwm_q;
    assign period_start = start_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel
//
// Scoreboard bench for pwm_multichannel with WIDTH=10 and CHANNELS=4. The
// stimulus process drives one cycle of inputs and pushes the hand-computed
// output for the following cycle. The monitor pops one entry at every falling
// edge and compares it with the outputs.

module tb_pwm_multichannel;

    typedef struct {
        logic [9:0] cntr;
        logic [3:0] pwm;
        logic       ps;
        logic       pend;
        string      name;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        en;
    logic        load;
    logic [9:0]  period;
    logic [39:0] duty;
    logic        mode;
    logic [9:0]  cntr;
    logic [3:0]  pwm_out;
    logic        period_start;
    logic        pending;

    exp_t        expQ[$];
    int          vectors;
    int          miscompares;
    logic [9:0]  centerSeq [8];

    pwm_multichannel #(
        .WIDTH    (10),
        .CHANNELS (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .load         (load),
        .period       (period),
        .duty         (duty),
        .mode         (mode),
        .cntr         (cntr),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .pending      (pending)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one expected entry against the outputs as they are now.
    task automatic checkOutput(input exp_t e);
        vectors++;
        if ({cntr, pwm_out, period_start, pending} !== {e.cntr, e.pwm, e.ps, e.pend}) begin
            miscompares++;
            $display("[TB] FAIL %s: got cntr=%0d pwm=%b ps=%b pend=%b, expected cntr=%0d pwm=%b ps=%b pend=%b",
                     e.name, cntr, pwm_out, period_start, pending, e.cntr, e.pwm, e.ps, e.pend);
        end
    endtask

    // Monitor: on every falling edge, check the entry for the cycle that the
    // previous rising edge produced.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic setCfg(input logic [9:0] p, input logic [9:0] d0, input logic [9:0] d1,
                          input logic [9:0] d2, input logic [9:0] d3, input logic m);
        period = p;
        duty   = {d3, d2, d1, d0};
        mode   = m;
    endtask

    // Drive one cycle of control inputs starting at a falling edge. Push the
    // outputs expected after the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [9:0] expC, input logic [3:0] expP,
                                 input logic expS, input logic expPend, input string name);
        exp_t x;
        resetn = r;
        en     = e;
        load   = l;
        @(posedge clk);
        x.cntr = expC;
        x.pwm  = expP;
        x.ps   = expS;
        x.pend = expPend;
        x.name = name;
        expQ.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int waitCycles;
        vectors     = 0;
        miscompares = 0;
        centerSeq   = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd3, 10'd2, 10'd1};
        resetn = 1'b0;
        en     = 1'b1;
        load   = 1'b1;
        setCfg(10'd5, 10'd7, 10'd7, 10'd7, 10'd7, 1'b1);
        @(negedge clk);

        // Reset is held with en and load high.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, 1'b1, 10'd0, 4'b0000, 1'b0, 1'b0, "reset");

        // Load while disabled takes effect at once: edge mode, P=9, D={0,3,10,1023}.
        setCfg(10'd9, 10'd0, 10'd3, 10'd10, 10'd1023, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 4'b0000, 1'b0, 1'b0, "cfgLoadDisabled");
        for (int k = 0; k < 26; k++) begin
            c = k % 10;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {1'b1, 1'b1, (c < 3), 1'b0},
                          (c == 0), 1'b0, "edgeP9");
        end

        // Double buffer: load P=4, D[0]=2 while cntr=5. The old period finishes first.
        setCfg(10'd4, 10'd2, 10'd3, 10'd10, 10'd1023, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd6, 4'b1100, 1'b0, 1'b1, "stageLoad");
        for (int k = 7; k <= 9; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(k), 4'b1100, 1'b0, 1'b1, "oldPeriodTail");
        for (int k = 0; k < 10; k++) begin
            c = k % 5;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {1'b1, 1'b1, (c < 3), (c < 2)},
                          (c == 0), 1'b0, "newPeriodP4");
        end

        // Load on the wrap edge (cntr=4=P) is applied directly: P=6, D={1,6,7,0}.
        setCfg(10'd6, 10'd1, 10'd6, 10'd7, 10'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 4'b0111, 1'b1, 1'b0, "loadOnWrap");
        for (int k = 1; k <= 7; k++) begin
            c = k % 7;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {1'b0, 1'b1, (c < 6), (c < 1)},
                          (c == 0), 1'b0, "periodP6");
        end

        // Two loads before the wrap: only the second (P=2, D={2,1,0,3}) applies.
        setCfg(10'd3, 10'd3, 10'd3, 10'd3, 10'd3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd1, 4'b0110, 1'b0, 1'b1, "firstLoad");
        setCfg(10'd2, 10'd2, 10'd1, 10'd0, 10'd3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd2, 4'b0110, 1'b0, 1'b1, "secondLoad");
        for (int k = 3; k <= 6; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(k), {1'b0, 1'b1, (k < 6), 1'b0},
                          1'b0, 1'b1, "tailBeforeWrap");
        for (int k = 0; k < 6; k++) begin
            c = k % 3;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {1'b1, 1'b0, (c < 1), (c < 2)},
                          (c == 0), 1'b0, "lastWriteWins");
        end

        // Center mode, loaded on the wrap edge: P=4, D={2,0,5,4}.
        setCfg(10'd4, 10'd2, 10'd0, 10'd5, 10'd4, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 4'b1101, 1'b1, 1'b0, "centerLoad");
        for (int k = 1; k < 16; k++) begin
            c = int'(centerSeq[k % 8]);
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {(c < 4), 1'b1, 1'b0, (c < 2)},
                          ((k % 8) == 0), 1'b0, "centerP4");
        end

        // P=0, loaded on the center wrap edge (down at cntr=1).
        setCfg(10'd0, 10'd1, 10'd0, 10'd0, 10'd1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 4'b1001, 1'b1, 1'b0, "zeroPeriodLoad");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 4'b1001, 1'b1, 1'b0, "zeroPeriod");

        // Enable handling.
        setCfg(10'd9, 10'd5, 10'd0, 10'd0, 10'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 4'b0001, 1'b1, 1'b0, "enLoad");
        for (int k = 1; k <= 3; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(k), 4'b0001, 1'b0, 1'b0, "enRun");
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 4'b0000, 1'b0, 1'b0, "disable");
        setCfg(10'd3, 10'd2, 10'd0, 10'd0, 10'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 4'b0000, 1'b0, 1'b0, "loadWhileDisabled");
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 4'b0000, 1'b0, 1'b0, "idle");
        for (int k = 0; k < 9; k++) begin
            c = k % 4;
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(c), {3'b000, (c < 2)},
                          (c == 0), 1'b0, "reEnable");
        end

        // A reset in mid-period drops the staged data.
        setCfg(10'd7, 10'd7, 10'd0, 10'd0, 10'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd1, 4'b0001, 1'b0, 1'b1, "stageBeforeReset");
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 4'b0000, 1'b0, 1'b0, "midReset");
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 4'b0000, 1'b1, 1'b0, "afterReset");
        for (int k = 1; k <= 2; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 10'(k), 4'b0000, 1'b0, 1'b0, "afterResetRun");

        // Drain the scoreboard within a bounded number of cycles.
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
